// File: rtl/fetch_redirect_ctrl.sv
// Fetch sequencer for the pipelined femtoRV32 core: owns the PC, runs the imem handshake, buffers one instruction, applies EX redirects.
// Define FETCH_REDIRECT_STATS_EN to get saturating redirect/drain counters; otherwise both count ports read zero.
module fetch_redirect_ctrl #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_take,
    input  logic [XLEN-1:0] ex_target,
    input  logic            stall,
    input  logic            id_ready,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            if_valid,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic            flush_ifid,
    output logic            flush_idex,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     redirect_cnt,
    output logic [31:0]     drain_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        REQ   = 2'd2,
        DRAIN = 2'd3
    } fetchState_t;

    fetchState_t     stateReg, stateNext;
    logic [XLEN-1:0] pcReg, pcNext;
    logic [XLEN-1:0] drainAddrReg, drainAddrNext;
    logic            validReg, validNext;
    logic [31:0]     instrReg, instrNext;
    logic [XLEN-1:0] ifPcReg, ifPcNext;
    logic            bufFree;
    logic            bufLoad;

    assign bufFree = !validReg || id_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg     <= IDLE;
            pcReg        <= RESET_PC;
            drainAddrReg <= '0;
            validReg     <= 1'b0;
            instrReg     <= '0;
            ifPcReg      <= '0;
        end else begin
            stateReg     <= stateNext;
            pcReg        <= pcNext;
            drainAddrReg <= drainAddrNext;
            validReg     <= validNext;
            instrReg     <= instrNext;
            ifPcReg      <= ifPcNext;
        end
    end

    always_comb begin
        stateNext     = stateReg;
        pcNext        = pcReg;
        drainAddrNext = drainAddrReg;
        validNext     = validReg;
        instrNext     = instrReg;
        ifPcNext      = ifPcReg;
        bufLoad       = 1'b0;
        imem_req      = 1'b0;
        imem_addr     = pcReg;

        unique case (stateReg)
            IDLE: begin
                stateNext = FETCH;
            end
            FETCH: begin
                if (bufFree && !stall && !ex_take) begin
                    stateNext = REQ;
                end
            end
            REQ: begin
                imem_req  = 1'b1;
                imem_addr = pcReg;
                if (imem_ack) begin
                    stateNext = FETCH;
                    bufLoad   = !ex_take;
                    pcNext    = pcReg + XLEN'(4);
                end else if (ex_take) begin
                    // Keep the abandoned request on the bus until memory answers it
                    stateNext     = DRAIN;
                    drainAddrNext = pcReg;
                end
            end
            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drainAddrReg;
                if (imem_ack) begin
                    stateNext = FETCH;
                end
            end
        endcase

        // Redirect beats a same-edge load, which beats consumption by decode
        if (ex_take) begin
            validNext = 1'b0;
            pcNext    = ex_target & ~XLEN'(3);
        end else if (bufLoad) begin
            validNext = 1'b1;
            instrNext = imem_rdata;
            ifPcNext  = pcReg;
        end else if (validReg && id_ready && !stall) begin
            validNext = 1'b0;
        end
    end

    assign flush_ifid = ex_take;
    assign flush_idex = ex_take;
    assign if_valid   = validReg;
    assign if_instr   = instrReg;
    assign if_pc      = ifPcReg;
    assign pc         = pcReg;

`ifdef FETCH_REDIRECT_STATS_EN
    logic [31:0] redirectCntReg;
    logic [31:0] drainCntReg;
    logic        drainHit;

    assign drainHit = imem_ack && ((stateReg == REQ && ex_take) || stateReg == DRAIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirectCntReg <= '0;
            drainCntReg    <= '0;
        end else begin
            if (ex_take && (redirectCntReg != 32'hFFFF_FFFF)) begin
                redirectCntReg <= redirectCntReg + 32'd1;
            end
            if (drainHit && (drainCntReg != 32'hFFFF_FFFF)) begin
                drainCntReg <= drainCntReg + 32'd1;
            end
        end
    end

    assign redirect_cnt = redirectCntReg;
    assign drain_cnt    = drainCntReg;
`else
    assign redirect_cnt = 32'h0;
    assign drain_cnt    = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed scenarios plus random traffic against a rule-level model of PC, buffer and handshake.
module tb_fetch_redirect_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ex_take = 1'b0;
    logic [31:0] ex_target = '0;
    logic        stall = 1'b0;
    logic        id_ready = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        flush_ifid;
    logic        flush_idex;
    logic [31:0] pc;
    logic [31:0] redirect_cnt;
    logic [31:0] drain_cnt;

    fetch_redirect_ctrl #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .ex_take(ex_take), .ex_target(ex_target),
        .stall(stall), .id_ready(id_ready), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_valid(if_valid),
        .if_instr(if_instr), .if_pc(if_pc), .flush_ifid(flush_ifid),
        .flush_idex(flush_idex), .pc(pc), .redirect_cnt(redirect_cnt), .drain_cnt(drain_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Stimulus knobs for the next cycle
    logic        nTake = 0, nStall = 0, nIdReady = 0;
    logic [31:0] nTarget = '0;
    int          memMin = 0, memMax = 0;

    // Memory responder state
    logic memBusy = 0;
    int   memLeft = 0;
    logic prevDutReq = 0;
    int   gCyc = 0;
    logic [31:0] logAddr[$];
    int          logCyc[$];

    // Reference model: architectural PC, IF/ID buffer, request ownership
    logic [31:0] mPc, mBufInstr, mBufPc, mReqAddr, mRedir, mDrain;
    logic        mBufValid, mCancel, prevReq, prevAck, prevOk;
    int          cyc;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, gCyc);
        end
    endtask

    function automatic logic [31:0] instrOf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic modelReset();
        mPc = RST_PC; mBufValid = 0; mBufInstr = '0; mBufPc = '0; mReqAddr = '0;
        mRedir = '0; mDrain = '0; mCancel = 0;
        prevReq = 0; prevAck = 0; prevOk = 0; cyc = 0;
        memBusy = 0; memLeft = 0; prevDutReq = 0;
        logAddr.delete(); logCyc.delete();
    endtask

    task automatic doReset();
        rst_n = 0; ex_take = 0; stall = 0; id_ready = 0; imem_ack = 0;
        nTake = 0; nStall = 0;
        #1;
        checkValue("rst_imem_req", imem_req, 0);
        checkValue("rst_if_valid", if_valid, 0);
        checkValue("rst_if_instr", if_instr, 32'h0);
        checkValue("rst_if_pc", if_pc, 32'h0);
        checkValue("rst_pc", pc, RST_PC);
        checkValue("rst_flush_ifid", flush_ifid, 0);
        checkValue("rst_redirect_cnt", redirect_cnt, 32'h0);
        checkValue("rst_drain_cnt", drain_cnt, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        modelReset();
    endtask

    task automatic stepCycle();
        logic expReq, ack, liveAck, wasValid;
        logic [31:0] expAddr;
        @(negedge clk);
        gCyc++;
        ex_take = nTake; ex_target = nTarget; stall = nStall; id_ready = nIdReady;
        if (imem_req) begin
            if (!memBusy) begin
                memBusy = 1;
                memLeft = $urandom_range(memMax, memMin);
            end
            if (memLeft == 0) begin
                imem_ack = 1; memBusy = 0;
            end else begin
                imem_ack = 0; memLeft--;
            end
            imem_rdata = imem_ack ? instrOf(imem_addr) : $urandom;
        end else begin
            imem_ack = 0; imem_rdata = $urandom;
        end
        if (imem_req && !prevDutReq) begin
            logAddr.push_back(imem_addr);
            logCyc.push_back(gCyc);
        end
        prevDutReq = imem_req;
        #1;

        // Request must appear right after an eligible FETCH cycle and hold until acked
        expReq = (cyc == 0) ? 1'b0 : (prevReq ? !prevAck : prevOk);
        checkValue("imem_req", imem_req, expReq);
        if (expReq) begin
            expAddr = prevReq ? mReqAddr : mPc;
            checkValue("imem_addr", imem_addr, expAddr);
        end
        checkValue("flush_ifid", flush_ifid, ex_take);
        checkValue("flush_idex", flush_idex, ex_take);
        checkValue("if_valid", if_valid, mBufValid);
        if (mBufValid) begin
            checkValue("if_instr", if_instr, mBufInstr);
            checkValue("if_pc", if_pc, mBufPc);
        end
        checkValue("pc", pc, mPc);
`ifdef FETCH_REDIRECT_STATS_EN
        checkValue("redirect_cnt", redirect_cnt, mRedir);
        checkValue("drain_cnt", drain_cnt, mDrain);
`else
        checkValue("redirect_cnt", redirect_cnt, 32'h0);
        checkValue("drain_cnt", drain_cnt, 32'h0);
`endif

        ack = imem_ack && expReq;
        if (expReq && !prevReq) begin
            mReqAddr = mPc;
            mCancel  = 0;
        end
        liveAck = ack && !mCancel && !ex_take;
        if (ack && (mCancel || ex_take) && mDrain != 32'hFFFF_FFFF) mDrain = mDrain + 1;
        if (ex_take && !ack) mCancel = 1;
        wasValid = mBufValid;
        prevOk = !stall && !ex_take && (!wasValid || id_ready);
        if (ex_take) begin
            mBufValid = 0;
            mPc = ex_target & 32'hFFFF_FFFC;
            if (mRedir != 32'hFFFF_FFFF) mRedir = mRedir + 1;
        end else if (liveAck) begin
            mBufValid = 1;
            mBufPc = mReqAddr;
            mBufInstr = instrOf(mReqAddr);
            mPc = mReqAddr + 32'd4;
            $display("fetch pc=%h instr=%h cycle=%0d", mReqAddr, instrOf(mReqAddr), gCyc);
        end else if (wasValid && id_ready && !stall) begin
            mBufValid = 0;
        end
        prevReq = expReq;
        prevAck = ack;
        cyc++;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    task automatic waitRise(input string tag);
        int n;
        n = 0;
        logAddr.delete(); logCyc.delete();
        while (logAddr.size() == 0 && n < 40) begin
            stepCycle();
            n++;
        end
        checkValue({tag, "_req_seen"}, 32'(logAddr.size() > 0), 1);
    endtask

    task automatic checkLog(input string tag, input int idx, input logic [31:0] expAddr);
        checkValue({tag, "_seen"}, 32'(logAddr.size() > idx), 1);
        if (logAddr.size() > idx) checkValue(tag, logAddr[idx], expAddr);
    endtask

    initial begin
        logic [31:0] expNext;
        int          takeCyc;
        logic        lastTake;
        #3;
        doReset();

        // Back-to-back fetch with single-cycle memory
        memMin = 0; memMax = 0; nIdReady = 1;
        runCycles(8);
        checkLog("a_addr0", 0, 32'h100);
        checkLog("a_addr1", 1, 32'h104);
        checkLog("a_addr2", 2, 32'h108);
        if (logCyc.size() > 2) begin
            checkValue("a_gap01", logCyc[1] - logCyc[0], 2);
            checkValue("a_gap12", logCyc[2] - logCyc[1], 2);
        end

        // Decode backpressure holds the buffer and blocks fetch
        nIdReady = 0;
        runCycles(8);
        checkValue("b_req_idle", imem_req, 0);
        checkValue("b_valid", if_valid, 1);
        expNext = mPc;
        logAddr.delete(); logCyc.delete();
        nIdReady = 1;
        runCycles(4);
        checkLog("b_resume", 0, expNext);

        // Redirect while the request is stuck: drain then fetch target
        memMin = 3; memMax = 3;
        waitRise("c");
        nTake = 1; nTarget = 32'h200;
        stepCycle();
        nTake = 0;
        logAddr.delete(); logCyc.delete();
        runCycles(10);
        checkLog("c_target", 0, 32'h200);

        // Redirect coinciding with ack: no drain cycle
        memMin = 1; memMax = 1;
        waitRise("d");
        nTake = 1; nTarget = 32'h300;
        stepCycle();
        takeCyc = gCyc;
        nTake = 0;
        logAddr.delete(); logCyc.delete();
        stepCycle();
        checkValue("d_valid_cleared", if_valid, 0);
        runCycles(5);
        checkLog("d_target", 0, 32'h300);
        if (logCyc.size() > 0) checkValue("d_latency", logCyc[0] - takeCyc, 2);

        // Stall with a request in flight
        memMin = 2; memMax = 2;
        waitRise("e");
        nStall = 1;
        runCycles(4);
        checkValue("e_no_req", imem_req, 0);
        checkValue("e_loaded", if_valid, 1);
        nStall = 0;
        runCycles(6);

        // PC wrap and target alignment
        memMin = 0; memMax = 0;
        nTake = 1; nTarget = 32'hFFFF_FFFC;
        stepCycle();
        nTake = 0;
        logAddr.delete(); logCyc.delete();
        runCycles(6);
        checkLog("f_top", 0, 32'hFFFF_FFFC);
        checkLog("f_wrap", 1, 32'h0000_0000);
        nTake = 1; nTarget = 32'h203;
        stepCycle();
        nTake = 0;
        logAddr.delete(); logCyc.delete();
        runCycles(6);
        checkLog("f_align", 0, 32'h200);

        // Reset dropped in the middle of an outstanding request
        memMin = 3; memMax = 3;
        waitRise("g");
        doReset();

        // Random traffic
        memMin = 0; memMax = 4;
        lastTake = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) doReset();
            nTake    = !lastTake && ($urandom_range(15, 0) == 0);
            nTarget  = ($urandom_range(7, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            nStall   = ($urandom_range(4, 0) == 0);
            nIdReady = ($urandom_range(2, 0) != 0);
            lastTake = nTake;
            stepCycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
- Fetch-stage sequencer for the pipelined femtoRV32 core. Owns the PC register and drives the instruction-memory request/acknowledge handshake.
- Holds one fetched instruction in a single-entry IF/ID buffer.
- Applies control-flow redirects resolved in EX (the branch/jump take decision plus target). On a redirect it flushes IF/ID and ID/EX and discards any in-flight fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- XLEN, 32, address/data width.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- ex_take  in  1  EX stage resolved a taken branch or jump this cycle (single-cycle pulse).
- ex_target  in  XLEN  redirect target, valid with ex_take.
- stall  in  1  hazard unit requests fetch freeze (load-use).
- id_ready  in  1  decode accepts the buffered instruction this cycle.
- imem_req  out  1  instruction memory request.
- imem_addr  out  XLEN  fetch address.
- imem_ack  in  1  memory returns data this cycle.
- imem_rdata  in  32  fetched instruction.
- if_valid  out  1  IF/ID buffer holds a valid instruction.
- if_instr  out  32  buffered instruction.
- if_pc  out  XLEN  PC of the buffered instruction.
- flush_ifid  out  1  kill IF/ID.
- flush_idex  out  1  kill ID/EX.
- pc  out  XLEN  current fetch PC.
- redirect_cnt  out  32  taken redirects (optional feature).
- drain_cnt  out  32  discarded in-flight fetches (optional feature).

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=IDLE.
  - imem_req=0, if_valid=0, if_instr=0, if_pc=0, flushes=0, counters=0.
- States:
  - IDLE: unconditionally moves to FETCH on the first clock after reset release.
  - FETCH: imem_req=0. Moves to REQ when the buffer is free and stall=0 and ex_take=0. The buffer is free when (!if_valid || id_ready).
  - REQ: imem_req=1, imem_addr=pc.
  - DRAIN: imem_req=1, imem_addr = the address of the cancelled request.
- Handshake rule: once imem_req rises, it stays high and imem_addr stays stable until the cycle imem_ack=1. This holds in both REQ and DRAIN, and regardless of stall or redirect.
- REQ, imem_ack=1, no ex_take:
  - if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4 (mod 2^XLEN wrap), state<=FETCH.
  - Fetch latency is therefore at least 2 cycles per instruction (FETCH then REQ).
- REQ, ex_take=1, imem_ack=0: pc<=ex_target, state<=DRAIN; the request stays up on the old address.
- REQ, ex_take=1, imem_ack=1: rdata is discarded, pc<=ex_target, state<=FETCH, drain_cnt increments.
- DRAIN, imem_ack=1: rdata is discarded, state<=FETCH, drain_cnt increments. A further ex_take in DRAIN only overwrites pc.
- Buffer consumption: id_ready=1 with if_valid=1 and stall=0 clears if_valid, unless a new ack loads the buffer in the same edge. Load wins.
- stall=1: the buffer is held and id_ready is ignored. No new request leaves FETCH; an in-flight REQ or DRAIN completes normally.
- ex_take=1 (highest priority):
  - flush_ifid=flush_idex=1 combinationally in the same cycle.
  - if_valid<=0 at the next edge; any same-edge ack is discarded.
  - pc<=ex_target, with ex_target[1:0] forced to 00.
  - redirect_cnt increments.
  - Redirect overrides both stall and id_ready.
- Flush outputs are 0 whenever ex_take=0.
- Reset asserted mid-REQ: imem_req drops immediately (async). The memory side must tolerate an abandoned request.

Optional Feature:
- FETCH_REDIRECT_STATS_EN defined: redirect_cnt and drain_cnt are 32-bit saturating counters (stick at 32'hFFFF_FFFF), reset to 0.
- Not defined: both ports are tied to 32'h0 and no counter flops are inferred.

Test Plan:
- Reset, RESET_PC=32'h100, memory acks one cycle after req, id_ready=1 -> imem_addr sequence 100,104,108; if_pc follows with 1-instruction lag; one instruction every 2 cycles.
- id_ready=0 with buffer full -> imem_req stays 0, if_valid=1, if_instr stable; raising id_ready -> fetch resumes at the next PC.
- ex_take=1 with ex_target=32'h200 while in REQ and ack delayed 3 cycles -> flush_ifid/flush_idex=1 that cycle, imem_addr holds the old address until ack, data discarded, next request at 200, drain_cnt=1.
- ex_take and imem_ack in the same cycle, target 32'h300 -> if_valid=0 after the edge, next imem_addr=300, no DRAIN cycle.
- stall=1 for 4 cycles with a request in flight -> ack is loaded into the buffer, no new request while stalled, buffer unchanged until stall=0 and id_ready=1.
- pc=32'hFFFF_FFFC fetch completes -> pc wraps to 32'h0; ex_target=32'h203 -> fetch at 32'h200.
